// File: rtl/cbb_dmux_mc_rx.sv
`timescale 1ns/1ps
// Toggle-handshake CDC receiver: P_CH_NUM async request/data channels merged round-robin onto one valid/ready stream.
// Optional sticky overrun detection is compiled in with CBB_DMUX_MC_OVERRUN_EN.
module cbb_dmux_mc_rx #(
    parameter int P_CH_NUM     = 4,
    parameter int P_DATA_WIDTH = 16,
    parameter int P_SYNC_STAGE = 2
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [P_CH_NUM-1:0]                           i_req_tgl,
    input  logic [P_CH_NUM*P_DATA_WIDTH-1:0]              i_data,
    output logic [P_CH_NUM-1:0]                           o_ack_tgl,
    output logic                                          o_valid,
    input  logic                                          i_ready,
    output logic [P_DATA_WIDTH-1:0]                       o_data,
    output logic [((P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1)-1:0] o_ch,
    output logic [P_CH_NUM-1:0]                           o_overrun
);
    localparam int CH_W = (P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1;
    typedef logic [CH_W-1:0] ch_t;

    logic [P_SYNC_STAGE-1:0] sync_q [P_CH_NUM];
    logic [P_SYNC_STAGE-1:0] sync_d [P_CH_NUM];
    logic [P_DATA_WIDTH-1:0] hold_q [P_CH_NUM];
    logic [P_DATA_WIDTH-1:0] hold_d [P_CH_NUM];
    logic [P_CH_NUM-1:0]     prev_q, prev_d;
    logic [P_CH_NUM-1:0]     pend_q, pend_d;
    logic [P_CH_NUM-1:0]     ack_q, ack_d;
    ch_t                     ptr_q, ptr_d;
    ch_t                     ch_q, ch_d;
    logic                    vld_q, vld_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;

    logic [P_CH_NUM-1:0]     req_edge;
    logic [P_CH_NUM-1:0]     busy;
    logic                    gnt_vld;
    ch_t                     gnt;
    logic [CH_W:0]           idx;

    always_comb begin
        sync_d  = sync_q;
        hold_d  = hold_q;
        prev_d  = prev_q;
        pend_d  = pend_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        vld_d   = vld_q;
        data_d  = data_q;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;

        for (int c = 0; c < P_CH_NUM; c++) begin
            req_edge[c] = sync_q[c][P_SYNC_STAGE-1] ^ prev_q[c];
            busy[c]     = pend_q[c] | (vld_q & (ch_q == ch_t'(c)));
            sync_d[c]   = {sync_q[c][P_SYNC_STAGE-2:0], i_req_tgl[c]};
            prev_d[c]   = sync_q[c][P_SYNC_STAGE-1];
            // A word arriving while its channel is busy is dropped: hold keeps the earlier word.
            if (req_edge[c] && !busy[c]) begin
                hold_d[c] = i_data[c*P_DATA_WIDTH +: P_DATA_WIDTH];
                pend_d[c] = 1'b1;
            end
        end

        // Round-robin: first pending index at or after the pointer, wrapping.
        for (int i = 0; i < P_CH_NUM; i++) begin
            idx = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(P_CH_NUM)) begin
                idx = idx - (CH_W+1)'(P_CH_NUM);
            end
            if (!gnt_vld && pend_q[idx[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt     = idx[CH_W-1:0];
            end
        end

        if (vld_q && i_ready) begin
            ack_d[ch_q] = ~ack_q[ch_q];
            vld_d       = 1'b0;
        end

        if ((!vld_q || i_ready) && gnt_vld) begin
            vld_d       = 1'b1;
            data_d      = hold_q[gnt];
            ch_d        = gnt;
            pend_d[gnt] = 1'b0;
            ptr_d       = (gnt == ch_t'(P_CH_NUM-1)) ? ch_t'(0) : gnt + ch_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < P_CH_NUM; c++) begin
                sync_q[c] <= '0;
                hold_q[c] <= '0;
            end
            prev_q <= '0;
            pend_q <= '0;
            ack_q  <= '0;
            ptr_q  <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            sync_q <= sync_d;
            hold_q <= hold_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
            ptr_q  <= ptr_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

`ifdef CBB_DMUX_MC_OVERRUN_EN
    logic [P_CH_NUM-1:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q | (req_edge & busy);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign o_overrun = ovr_q;
`else
    assign o_overrun = '0;
`endif

    assign o_ack_tgl = ack_q;
    assign o_valid   = vld_q;
    assign o_data    = data_q;
    assign o_ch      = ch_q;

endmodule

// File: tb/tb_cbb_dmux_mc_rx.sv
`timescale 1ns/1ps
// Bench for cbb_dmux_mc_rx: per-cycle vector table, directed overrun/reset sequences, async-source soak.
module tb_cbb_dmux_mc_rx;

    localparam int SOAK_PER = 1250;

`ifdef CBB_DMUX_MC_OVERRUN_EN
    localparam logic [3:0] OVR_EXP = 4'b1000;
`else
    localparam logic [3:0] OVR_EXP = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        soak_en = 1'b0;
    logic [3:0]  dir_tgl = '0;
    logic [63:0] dir_dat = '0;
    wire  [3:0]  soak_tgl;
    wire  [63:0] soak_dat;
    logic [3:0]  req_tgl;
    logic [63:0] req_dat;
    logic [3:0]  o_ack_tgl;
    logic        o_valid;
    logic [15:0] o_data;
    logic [1:0]  o_ch;
    logic [3:0]  o_overrun;

    assign req_tgl = soak_en ? soak_tgl : dir_tgl;
    assign req_dat = soak_en ? soak_dat : dir_dat;

    always #5 clk = ~clk;

    cbb_dmux_mc_rx #(
        .P_CH_NUM     (4),
        .P_DATA_WIDTH (16),
        .P_SYNC_STAGE (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req_tgl (req_tgl),
        .i_data    (req_dat),
        .o_ack_tgl (o_ack_tgl),
        .o_valid   (o_valid),
        .i_ready   (rdy),
        .o_data    (o_data),
        .o_ch      (o_ch),
        .o_overrun (o_overrun)
    );

    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    logic [1:0]  log_ch [$];
    logic [15:0] exp_q [4][$];
    logic [15:0] exp_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the oldest outstanding word of its channel.
    always @(negedge clk) begin
        if (!rst && o_valid && rdy) begin
            hs_cnt++;
            log_ch.push_back(o_ch);
            if (exp_q[o_ch].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra: ch=%0d data=%h, expected no word", o_ch, o_data);
            end else begin
                exp_w = exp_q[o_ch].pop_front();
                chk("sb_data", 64'(o_data), 64'(exp_w));
            end
        end
    end

    // Compliant asynchronous sources for the soak phase.
    for (genvar c = 0; c < 4; c++) begin : g_src
        localparam real HP = (c == 0) ? 3.5 : (c == 1) ? 5.0 : (c == 2) ? 6.5 : 11.5;
        logic        sclk = 1'b0;
        logic        req_l = 1'b0;
        logic [15:0] dat_l = '0;
        logic [15:0] nd;
        logic [1:0]  ack_s = '0;
        int          sent = 0;

        initial begin
            #(0.3);
            forever #(HP) sclk = ~sclk;
        end

        always @(posedge sclk) begin
            ack_s <= {ack_s[0], o_ack_tgl[c]};
            if (soak_en && ack_s[1] == req_l && sent < SOAK_PER && $urandom_range(0, 3) != 0) begin
                nd = 16'($urandom);
                exp_q[c].push_back(nd);
                dat_l <= nd;
                req_l <= ~req_l;
                sent  <= sent + 1;
            end
        end

        assign soak_tgl[c]           = req_l;
        assign soak_dat[c*16 +: 16]  = dat_l;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  tgl;
        logic [63:0] dat;
        logic        rdy;
        logic        vld;
        logic        chk_dat;
        logic [1:0]  ch;
        logic [15:0] odat;
        logic [3:0]  ack;
    } vec_t;

    vec_t tbl [$];

    task automatic row(input int n, input logic r, input logic [3:0] t, input logic [63:0] d,
                       input logic rd, input logic v, input logic cd, input logic [1:0] ch,
                       input logic [15:0] od, input logic [3:0] ack);
        vec_t e;
        e.rst = r; e.tgl = t; e.dat = d; e.rdy = rd; e.vld = v;
        e.chk_dat = cd; e.ch = ch; e.odat = od; e.ack = ack;
        repeat (n) tbl.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] t, input logic [63:0] d, input logic push);
        for (int c = 0; c < 4; c++) begin
            if (push && t[c] != dir_tgl[c]) exp_q[c].push_back(d[c*16 +: 16]);
        end
        dir_tgl = t;
        dir_dat = d;
    endtask

    task automatic clear_sb();
        for (int c = 0; c < 4; c++) exp_q[c].delete();
    endtask

    int n0;
    int hs0;
    logic timeout;

    initial begin
        localparam logic [63:0] D_ALL = 64'h4444_3333_2222_1111;
        localparam logic [63:0] D_13  = 64'h5353_0000_5151_0000;
        // rows: n, rst, tgl, dat, rdy | vld, chk_dat, ch, odat, ack
        row(1, 1, 4'b0000, 64'h0, 1,   0, 1, 2'd0, 16'h0000, 4'b0000);
        row(1, 0, 4'b0100, 64'h0000_A5C3_0000_0000, 1, 0, 0, 2'd0, 16'h0, 4'b0000);
        row(3, 0, 4'b0100, 64'h0000_A5C3_0000_0000, 1, 0, 0, 2'd0, 16'h0, 4'b0000);
        row(1, 0, 4'b0100, 64'h0000_A5C3_0000_0000, 1, 1, 1, 2'd2, 16'hA5C3, 4'b0000);
        row(1, 0, 4'b0100, 64'h0, 1,   0, 0, 2'd0, 16'h0, 4'b0100);
        row(1, 1, 4'b0000, 64'h0, 1,   0, 0, 2'd0, 16'h0, 4'b0100);
        row(1, 1, 4'b0000, 64'h0, 1,   0, 1, 2'd0, 16'h0000, 4'b0000);
        row(4, 0, 4'b1111, D_ALL, 1,   0, 0, 2'd0, 16'h0, 4'b0000);
        row(1, 0, 4'b1111, D_ALL, 1,   1, 1, 2'd0, 16'h1111, 4'b0000);
        row(1, 0, 4'b1111, D_ALL, 1,   1, 1, 2'd1, 16'h2222, 4'b0001);
        row(1, 0, 4'b1111, D_ALL, 1,   1, 1, 2'd2, 16'h3333, 4'b0011);
        row(1, 0, 4'b1111, D_ALL, 1,   1, 1, 2'd3, 16'h4444, 4'b0111);
        row(1, 0, 4'b1111, D_ALL, 1,   0, 0, 2'd0, 16'h0, 4'b1111);
        row(4, 0, 4'b0101, D_13, 1,    0, 0, 2'd0, 16'h0, 4'b1111);
        row(1, 0, 4'b0101, D_13, 1,    1, 1, 2'd1, 16'h5151, 4'b1111);
        row(1, 0, 4'b0101, D_13, 1,    1, 1, 2'd3, 16'h5353, 4'b1101);
        row(1, 0, 4'b0101, D_13, 1,    0, 0, 2'd0, 16'h0, 4'b0101);
        row(4, 0, 4'b0100, 64'hBEEF, 0, 0, 0, 2'd0, 16'h0, 4'b0101);
        row(10, 0, 4'b0100, 64'hBEEF, 0, 1, 1, 2'd0, 16'hBEEF, 4'b0101);
        row(1, 0, 4'b0100, 64'hBEEF, 1, 1, 1, 2'd0, 16'hBEEF, 4'b0101);
        row(2, 0, 4'b0100, 64'hBEEF, 1, 0, 0, 2'd0, 16'h0, 4'b0100);

        rst = 1'b1;
        repeat (3) tick();

        foreach (tbl[i]) begin
            tick();
            if (tbl[i].rst) clear_sb();
            drive(tbl[i].tgl, tbl[i].dat, !tbl[i].rst);
            rst = tbl[i].rst;
            rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d_vld", i), 64'(o_valid), 64'(tbl[i].vld));
            chk($sformatf("row%0d_ack", i), 64'(o_ack_tgl), 64'(tbl[i].ack));
            chk($sformatf("row%0d_ovr", i), 64'(o_overrun), 64'(0));
            if (tbl[i].chk_dat) begin
                chk($sformatf("row%0d_ch", i), 64'(o_ch), 64'(tbl[i].ch));
                chk($sformatf("row%0d_dat", i), 64'(o_data), 64'(tbl[i].odat));
            end
        end

        // Overrun: ch3 toggles again while its first word is still held at the output.
        tick();
        rdy = 1'b0;
        drive(4'b1100, 64'h0001_0000_0000_0000, 1);
        repeat (3) tick();
        drive(4'b0100, 64'h0002_0000_0000_0000, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("ovr_vld", 64'(o_valid), 64'(1));
        chk("ovr_ch", 64'(o_ch), 64'(3));
        chk("ovr_dat", 64'(o_data), 64'h0001);
        chk("ovr_flag", 64'(o_overrun), 64'(OVR_EXP));
        chk("ovr_ack_hold", 64'(o_ack_tgl), 64'(4'b0100));
        tick();
        rdy = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("ovr_idle", 64'(o_valid), 64'(0));
        chk("ovr_ack", 64'(o_ack_tgl), 64'(4'b1100));
        chk("ovr_sticky", 64'(o_overrun), 64'(OVR_EXP));
        chk("ovr_drop", 64'(exp_q[3].size()), 64'(0));

        // Reset while one word is presented and two more are pending.
        tick();
        rdy = 1'b0;
        drive(4'b0011, 64'h0000_C2C2_C1C1_C0C0, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("rst_pre_vld", 64'(o_valid), 64'(1));
        chk("rst_pre_ch", 64'(o_ch), 64'(0));
        tick();
        rst = 1'b1;
        dir_tgl = '0;
        clear_sb();
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        chk("rst_vld", 64'(o_valid), 64'(0));
        chk("rst_dat", 64'(o_data), 64'(0));
        chk("rst_ch", 64'(o_ch), 64'(0));
        chk("rst_ack", 64'(o_ack_tgl), 64'(0));
        chk("rst_ovr", 64'(o_overrun), 64'(0));
        hs0 = hs_cnt;
        repeat (10) tick();
        @(negedge clk);
        chk("rst_no_stale", 64'(hs_cnt), 64'(hs0));
        n0 = log_ch.size();
        tick();
        drive(4'b0101, 64'h0000_D2D2_0000_D0D0, 1);
        repeat (8) tick();
        @(negedge clk);
        chk("rst_ptr_cnt", 64'(log_ch.size() - n0), 64'(2));
        if (log_ch.size() >= n0 + 2) begin
            chk("rst_ptr_first", 64'(log_ch[n0]), 64'(0));
            chk("rst_ptr_second", 64'(log_ch[n0+1]), 64'(2));
        end

        // Soak with four free-running source clocks and random downstream stalls.
        tick();
        rst = 1'b1;
        dir_tgl = '0;
        clear_sb();
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        hs0 = hs_cnt;
        soak_en = 1'b1;
        timeout = 1'b1;
        for (int k = 0; k < 60000; k++) begin
            tick();
            rdy = ($urandom_range(0, 3) != 0);
            if (g_src[0].sent == SOAK_PER && g_src[1].sent == SOAK_PER &&
                g_src[2].sent == SOAK_PER && g_src[3].sent == SOAK_PER &&
                exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[2].size() == 0 && exp_q[3].size() == 0) begin
                timeout = 1'b0;
                break;
            end
        end
        @(negedge clk);
        chk("soak_timeout", 64'(timeout), 64'(0));
        chk("soak_words", 64'(hs_cnt - hs0), 64'(4 * SOAK_PER));
        chk("soak_ovr", 64'(o_overrun), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
